cnnip_unpacker: RTL and testbench
=================================

# cnnip_unpacker

Stream unpacker that sits directly downstream of the single-clock CNN IP FIFO. On a start command it pops WIDTH-bit words from the FIFO (show-ahead: data valid whenever not empty), splits each word into LANES = WIDTH/DW elements, and emits them one per cycle on a valid/ready stream with a last flag. The stream feeds the convolution datapath. Frame length is given in elements; the block issues exactly ceil(len/LANES) pops per frame.

## Interface
- WIDTH, 32, FIFO word width; must be an integer multiple of DW
- DW, 8, output element width
- LEN_W, 16, width of the element-count field
- clk_a  in  1  clock
- arstz_aq  in  1  reset, asynchronous, active-low
- start_a  in  1  frame start pulse; sampled only in IDLE
- len_a  in  LEN_W  frame length in elements; latched when start_a is accepted
- busy_a  out  1  high from the cycle after start is accepted until done
- done_a  out  1  one-cycle pulse at frame end
- fifo_empty_a  in  1  FIFO empty flag
- fifo_dout_a  in  WIDTH  FIFO head word, valid when !fifo_empty_a
- fifo_pop_a  out  1  FIFO pop, combinational
- m_valid_a  out  1  output element valid
- m_ready_a  in  1  downstream ready
- m_data_a  out  DW  output element
- m_last_a  out  1  final element of frame, qualified by m_valid_a

## Operation
- States:
  - IDLE: start_a=1 latches len_a. If len_a≠0, go to RUN and load words_left = ceil(len_a/LANES) and elem_left = len_a. If len_a=0, go to DONE with no pops.
  - RUN: unpack as below. Go to DONE on the fire (valid&ready) of the last element.
  - DONE: done_a=1 for exactly one cycle, then return to IDLE.
- Holding register word_q, flag word_vld, lane index lane (0..LANES-1).
- fifo_pop_a = RUN & !fifo_empty_a & words_left≠0 & (!word_vld | (fire & lane==LANES-1 & !m_last_a)).
- On pop: word_q←fifo_dout_a, word_vld←1, lane←0, words_left−1.
- m_valid_a = word_vld. m_data_a = word_q[lane*DW +: DW], so lane 0 (LSBs) is emitted first.
- On fire: lane increments and elem_left decrements.
  - lane==LANES-1 with no pop in the same cycle: word_vld←0.
- m_last_a = m_valid_a & elem_left==1.
- On fire with m_last_a: word_vld←0 and lane←0. Remaining lanes of a partial last word are discarded.
- start_a outside IDLE is ignored.
- fifo_pop_a is never asserted while fifo_empty_a=1, and never more than ceil(len/LANES) times per frame.
- m_data_a/m_valid_a are held stable while m_valid_a & !m_ready_a.

## Timing
- Reset values:
  - state IDLE
  - busy_a=0, done_a=0, fifo_pop_a=0, m_valid_a=0, m_last_a=0, m_data_a=0
  - word_vld=0, all counters 0
- Reset mid-frame aborts immediately with no done pulse. FIFO contents are not touched; the parent flushes them.
- start accepted at edge t → busy_a=1 from cycle t+1. With the FIFO non-empty, first pop in cycle t+1 and first m_valid_a in cycle t+2.
- Throughput with m_ready_a=1 and FIFO never empty: one element per cycle, no bubbles across word boundaries. The pop coincides with the fire of lane LANES-1.
- FIFO empty at a word boundary: m_valid_a=0 until the cycle after the pop.
- Last fire at edge t → done_a=1 and busy_a=1 in cycle t+1 (DONE state); IDLE and busy_a=0 in cycle t+2.

## Structure
- Shared package cnnip_pkg holds:
  - typedef enum logic [1:0] {IDLE, RUN, DONE} unpack_state_t
  - a function computing ceil division, for words_left
- LANES = WIDTH/DW is a local constant, with an elaboration-time check WIDTH % DW == 0.
- No sub-module: the FIFO is instantiated by the parent. Lane select is an indexed part-select, not a separate mux module.

## Test plan
- WIDTH=32, DW=8, len=8, FIFO holds 0x03020100 and 0x07060504, ready=1 → m_data 00..07 on 8 consecutive cycles; m_last on 07; exactly 2 pops; done pulse one cycle after 07.
- len=5, same data → 00..04 emitted, m_last on 04; 2 pops; bytes 05..07 never appear; third FIFO word untouched.
- len=8 with m_ready_a toggling 1,0,0,1,… → data held stable during stalls; order 00..07 preserved; no extra pops.
- FIFO empty for 3 cycles between words → m_valid_a drops, no pop while empty; resumes with 04 the cycle after the pop.
- len=0 → no pops, no m_valid_a; done_a pulse 1 cycle after start; start_a during RUN ignored (len unchanged).
- arstz_aq low after the 3rd element → all outputs 0 immediately; no done; a new start afterwards runs a clean frame.

Source files
------------

// File: rtl/cnnip_pkg.sv
// Shared types and helpers for the CNN IP stream blocks.
// Holds the unpacker state encoding and a ceil-division helper.
package cnnip_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } unpack_state_t;

  function automatic int unsigned ceil_div(
    input int unsigned n,
    input int unsigned d
  );
    return (n + d - 1) / d;
  endfunction

endpackage

// File: rtl/cnnip_unpacker_if.sv
// Element stream bundle between the unpacker and the conv datapath.
// Valid/ready handshake with a frame-end flag.
interface cnnip_unpacker_if #(
  parameter int DW = 8
);
  import cnnip_pkg::*;

  logic          m_valid_a;
  logic          m_ready_a;
  logic [DW-1:0] m_data_a;
  logic          m_last_a;

  modport master (
    output m_valid_a,
    output m_data_a,
    output m_last_a,
    input  m_ready_a
  );

  modport slave (
    input  m_valid_a,
    input  m_data_a,
    input  m_last_a,
    output m_ready_a
  );

endinterface

// File: rtl/cnnip_unpacker.sv
// Pops WIDTH-bit words from a show-ahead FIFO and emits them as
// DW-bit elements, LSB lane first, one per cycle with a last flag.
module cnnip_unpacker
  import cnnip_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DW    = 8,
  parameter int LEN_W = 16
) (
  input  logic             clk_a,
  input  logic             arstz_aq,
  input  logic             start_a,
  input  logic [LEN_W-1:0] len_a,
  output logic             busy_a,
  output logic             done_a,
  input  logic             fifo_empty_a,
  input  logic [WIDTH-1:0] fifo_dout_a,
  output logic             fifo_pop_a,
  cnnip_unpacker_if.master m
);

  localparam int LANES  = WIDTH / DW;
  localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;
  localparam logic [LANE_W-1:0] LANE_MAX = LANE_W'(LANES - 1);

  generate
    if (WIDTH % DW != 0) begin : g_width_chk
      $error("cnnip_unpacker: WIDTH must be a multiple of DW");
    end
  endgenerate

  unpack_state_t state_q;
  unpack_state_t state_d;

  logic [WIDTH-1:0]  word_q;
  logic              word_vld;
  logic [LANE_W-1:0] lane;
  logic [LEN_W-1:0]  words_left;
  logic [LEN_W-1:0]  elem_left;

  logic accept;
  logic fire;
  logic last;
  logic lane_end;
  logic pop;

  assign accept   = (state_q == IDLE) && start_a;
  assign fire     = word_vld && m.m_ready_a;
  assign last     = word_vld && (elem_left == LEN_W'(1));
  assign lane_end = (lane == LANE_MAX);

  // Refill either into an empty holder or exactly as the final lane
  // of a non-terminal word leaves, so word boundaries cost no bubble.
  assign pop = (state_q == RUN)
            && !fifo_empty_a
            && (words_left != '0)
            && (!word_vld || (fire && lane_end && !last));

  assign fifo_pop_a  = pop;
  assign m.m_valid_a = word_vld;
  assign m.m_data_a  = word_q[lane*DW +: DW];
  assign m.m_last_a  = last;

  assign busy_a = (state_q != IDLE);
  assign done_a = (state_q == DONE);

  always_ff @(posedge clk_a or negedge arstz_aq) begin
    if (!arstz_aq) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (start_a) begin
          state_d = (len_a == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (fire && last) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_a or negedge arstz_aq) begin
    if (!arstz_aq) begin
      word_q     <= '0;
      word_vld   <= 1'b0;
      lane       <= '0;
      words_left <= '0;
      elem_left  <= '0;
    end else begin
      if (accept) begin
        words_left <= LEN_W'(ceil_div(32'(len_a), 32'(LANES)));
        elem_left  <= len_a;
      end else begin
        if (pop) begin
          words_left <= words_left - LEN_W'(1);
        end
        if (fire) begin
          elem_left <= elem_left - LEN_W'(1);
        end
      end

      if (pop) begin
        word_q   <= fifo_dout_a;
        word_vld <= 1'b1;
        lane     <= '0;
      end else if (fire) begin
        // A partial final word drops its unused upper lanes here.
        if (last || lane_end) begin
          word_vld <= 1'b0;
          lane     <= '0;
        end else begin
          lane <= lane + LANE_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_cnnip_unpacker.sv
// Directed bench for cnnip_unpacker with a show-ahead FIFO model
// and a negedge stream monitor.
module tb_cnnip_unpacker;

  logic        clk_a = 1'b0;
  logic        arstz_aq = 1'b0;
  logic        start_a = 1'b0;
  logic [15:0] len_a = '0;
  logic        busy_a;
  logic        done_a;
  logic        fifo_empty_a;
  logic [31:0] fifo_dout_a;
  logic        fifo_pop_a;

  cnnip_unpacker_if #(.DW(8)) u ();

  cnnip_unpacker #(
    .WIDTH(32),
    .DW   (8),
    .LEN_W(16)
  ) dut (
    .clk_a       (clk_a),
    .arstz_aq    (arstz_aq),
    .start_a     (start_a),
    .len_a       (len_a),
    .busy_a      (busy_a),
    .done_a      (done_a),
    .fifo_empty_a(fifo_empty_a),
    .fifo_dout_a (fifo_dout_a),
    .fifo_pop_a  (fifo_pop_a),
    .m           (u.master)
  );

  always #5 clk_a = ~clk_a;

  logic [31:0] mem [0:255];
  logic [7:0]  rd = '0;
  logic [7:0]  wr = '0;

  assign fifo_empty_a = (rd == wr);
  assign fifo_dout_a  = mem[rd];

  always @(posedge clk_a) begin
    if (arstz_aq && fifo_pop_a) rd <= rd + 8'd1;
  end

  int cyc = 0;
  int np = 0;
  int nrec = 0;
  int nd = 0;
  int pop_bad = 0;
  int stall_bad = 0;
  int done_cyc = 0;
  int pop_cyc [0:255];
  int rec_cyc [0:255];
  logic [7:0] rec_data [0:255];
  logic       rec_last [0:255];
  bit         stall_pend = 0;
  logic [7:0] hold_data = '0;

  always @(negedge clk_a) begin
    if (arstz_aq) begin
      if (fifo_pop_a) begin
        pop_cyc[np] = cyc;
        np++;
        if (fifo_empty_a) pop_bad++;
      end
      if (stall_pend && !(u.m_valid_a && u.m_data_a == hold_data))
        stall_bad++;
      stall_pend = u.m_valid_a && !u.m_ready_a;
      hold_data  = u.m_data_a;
      if (u.m_valid_a && u.m_ready_a) begin
        rec_data[nrec] = u.m_data_a;
        rec_last[nrec] = u.m_last_a;
        rec_cyc[nrec]  = cyc;
        nrec++;
      end
      if (done_a) begin
        done_cyc = cyc;
        nd++;
      end
      cyc++;
    end else begin
      stall_pend = 0;
    end
  end

  int nchk = 0;
  int nerr = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic push(input logic [31:0] w);
    mem[wr] = w;
    wr = wr + 8'd1;
  endtask

  task automatic flush();
    wr = rd;
  endtask

  task automatic load2();
    flush();
    push(32'h03020100);
    push(32'h07060504);
  endtask

  task automatic tick();
    @(posedge clk_a);
    #1;
  endtask

  task automatic at_neg();
    @(negedge clk_a);
    #1;
  endtask

  task automatic start_frame(input logic [15:0] l);
    tick();
    start_a = 1'b1;
    len_a   = l;
    tick();
    start_a = 1'b0;
  endtask

  // pat 0: ready high; 1: ready 0,0,1 plus a stray start; 2: late word
  task automatic run_wait(input int base_nd, input int pat,
                          input int budget);
    bit ok = 0;
    for (int j = 0; j < budget; j++) begin
      at_neg();
      if (nd > base_nd) begin
        ok = 1;
        break;
      end
      tick();
      if (pat == 1) begin
        u.m_ready_a = ((j + 1) % 3 == 0);
        start_a = (j == 2);
        if (j == 2) len_a = 16'd3;
      end
      if (pat == 2 && j == 6) push(32'h07060504);
    end
    chk("done_timeout", 32'(ok), 32'd1);
    u.m_ready_a = 1'b1;
    start_a = 1'b0;
  endtask

  task automatic check_frame(input string tag, input int b, input int pb,
                             input int n, input int pops);
    chk({tag, "_count"}, nrec - b, n);
    chk({tag, "_pops"}, np - pb, pops);
    for (int i = 0; i < n && i < nrec - b; i++) begin
      chk($sformatf("%s_data%0d", tag, i), 32'(rec_data[b+i]), i);
      chk($sformatf("%s_last%0d", tag, i), 32'(rec_last[b+i]),
          32'(i == n - 1));
    end
  endtask

  int b;
  int pb;
  int dnb;
  int sb;

  initial begin
    u.m_ready_a = 1'b1;
    #1;
    chk("rst_busy", 32'(busy_a), 0);
    chk("rst_done", 32'(done_a), 0);
    chk("rst_pop", 32'(fifo_pop_a), 0);
    chk("rst_valid", 32'(u.m_valid_a), 0);
    chk("rst_last", 32'(u.m_last_a), 0);
    chk("rst_data", 32'(u.m_data_a), 0);
    tick();
    arstz_aq = 1'b1;

    // len 8, full-rate stream
    load2();
    b = nrec; pb = np; dnb = nd;
    start_frame(16'd8);
    at_neg();
    chk("t1_busy", 32'(busy_a), 1);
    chk("t1_pop1", 32'(fifo_pop_a), 1);
    chk("t1_valid0", 32'(u.m_valid_a), 0);
    at_neg();
    chk("t1_valid1", 32'(u.m_valid_a), 1);
    chk("t1_first", 32'(u.m_data_a), 0);
    run_wait(dnb, 0, 40);
    chk("t1_done", 32'(done_a), 1);
    chk("t1_busy_done", 32'(busy_a), 1);
    check_frame("t1", b, pb, 8, 2);
    chk("t1_nobubble", rec_cyc[b+7] - rec_cyc[b], 7);
    chk("t1_pop_at_lane3", rec_cyc[b+3], pop_cyc[pb+1]);
    chk("t1_done_cyc", done_cyc, rec_cyc[b+7] + 1);
    at_neg();
    chk("t1_idle_busy", 32'(busy_a), 0);
    chk("t1_idle_done", 32'(done_a), 0);
    chk("t1_done_cnt", nd - dnb, 1);

    // len 5, partial last word, third word left alone
    load2();
    push(32'h0B0A0908);
    b = nrec; pb = np; dnb = nd;
    start_frame(16'd5);
    run_wait(dnb, 0, 40);
    check_frame("t2", b, pb, 5, 2);
    at_neg();
    chk("t2_left", 32'(wr - rd), 1);
    chk("t2_head", fifo_dout_a, 32'h0B0A0908);

    // len 8, ready toggling, stray start ignored
    load2();
    b = nrec; pb = np; dnb = nd; sb = stall_bad;
    start_frame(16'd8);
    run_wait(dnb, 1, 80);
    check_frame("t3", b, pb, 8, 2);
    chk("t3_stable", stall_bad - sb, 0);
    at_neg();

    // FIFO dry between words
    flush();
    push(32'h03020100);
    b = nrec; pb = np; dnb = nd;
    start_frame(16'd8);
    run_wait(dnb, 2, 60);
    check_frame("t4", b, pb, 8, 2);
    chk("t4_gap", 32'((rec_cyc[b+4] - rec_cyc[b+3]) > 1), 1);
    chk("t4_resume", rec_cyc[b+4], pop_cyc[pb+1] + 1);
    chk("t4_pop_empty", pop_bad, 0);
    at_neg();

    // len 0
    load2();
    b = nrec; pb = np; dnb = nd;
    start_frame(16'd0);
    at_neg();
    chk("t5_busy", 32'(busy_a), 1);
    chk("t5_done", 32'(done_a), 1);
    chk("t5_pop", 32'(fifo_pop_a), 0);
    chk("t5_valid", 32'(u.m_valid_a), 0);
    at_neg();
    chk("t5_idle", 32'(busy_a), 0);
    chk("t5_done_off", 32'(done_a), 0);
    chk("t5_pops", np - pb, 0);
    chk("t5_elems", nrec - b, 0);
    chk("t5_done_cnt", nd - dnb, 1);

    // reset after the 3rd element, then a clean frame
    load2();
    b = nrec; dnb = nd;
    start_frame(16'd8);
    for (int j = 0; j < 20 && nrec - b < 3; j++) at_neg();
    chk("t6_three", nrec - b, 3);
    tick();
    arstz_aq = 1'b0;
    #1;
    chk("t6_busy", 32'(busy_a), 0);
    chk("t6_done", 32'(done_a), 0);
    chk("t6_pop", 32'(fifo_pop_a), 0);
    chk("t6_valid", 32'(u.m_valid_a), 0);
    chk("t6_last", 32'(u.m_last_a), 0);
    chk("t6_data", 32'(u.m_data_a), 0);
    tick();
    tick();
    arstz_aq = 1'b1;
    at_neg();
    at_neg();
    chk("t6_nodone", nd - dnb, 0);
    load2();
    b = nrec; pb = np; dnb = nd;
    start_frame(16'd8);
    run_wait(dnb, 0, 40);
    check_frame("t6", b, pb, 8, 2);
    chk("pop_empty_total", pop_bad, 0);

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule
